// File: rtl/load_pkg.sv
// Shared definitions for the load path: funct3 codes, FSM states, fault causes
// and the funct3 size/sign decode.
package load_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_BAD = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ0  = 3'd1,
      S_WAIT0 = 3'd2,
      S_REQ1  = 3'd3,
      S_WAIT1 = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_MISALIGN = 2'd1,
      CAUSE_BUS      = 2'd2,
      CAUSE_ILLEGAL  = 2'd3
   } cause_t;

   typedef struct packed {
      logic [3:0] size;
      logic       sgn;
   } size_dec_t;

   // Access width in bytes is 2**funct3[1:0]; funct3[2] selects zero extension.
   function automatic size_dec_t decode_size(input logic [2:0] f3);
      size_dec_t d;
      d.size = 4'd1 << f3[1:0];
      d.sgn  = ~f3[2];
      return d;
   endfunction

   function automatic logic is_illegal(input logic [2:0] f3, input logic is64);
      return (f3 == F3_BAD) || (!is64 && (f3 == F3_LD || f3 == F3_LWU));
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte-lane extraction: shift {hi,lo} down by the byte offset,
// keep the accessed bytes and sign- or zero-extend them to XLEN.
module load_extract #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]            lo,
   input  logic [XLEN-1:0]            hi,
   input  logic [$clog2(XLEN/8)-1:0]  off,
   input  logic [3:0]                 size,
   input  logic                       sgn,
   output logic [XLEN-1:0]            data
);

   logic [XLEN-1:0] window;
   logic [XLEN-1:0] mask;
   logic            sbit;

   always_comb begin
      window = XLEN'({hi, lo} >> {off, 3'b000});
      case (size)
         4'd1:    mask = XLEN'(64'h0000_0000_0000_00FF);
         4'd2:    mask = XLEN'(64'h0000_0000_0000_FFFF);
         4'd4:    mask = XLEN'(64'h0000_0000_FFFF_FFFF);
         default: mask = '1;
      endcase
      // Top set bit of the mask marks the sign bit of the accessed field.
      sbit = |(window & mask & ~(mask >> 1));
      data = (window & mask) | ((sgn && sbit) ? ~mask : '0);
   end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load FSM: accepts one load, issues one or two aligned bus reads
// and returns the extended result or a fault cause.
module load_unit
   import load_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int MISALIGN_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_err,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_data,
   output logic              resp_err,
   output logic [1:0]        resp_cause,
   output logic [2:0]        state_dbg
);

   localparam int BYTES = XLEN / 8;
   localparam int OFF_W = $clog2(BYTES);

   state_t           state;
   logic [OFF_W-1:0] off_q;
   logic [3:0]       size_q;
   logic             sgn_q;
   logic             cross_q;
   logic [XLEN-1:0]  lo_q;

   size_dec_t        dec;
   logic [OFF_W-1:0] req_off;
   logic             req_cross;
   logic             req_bad;
   logic [ADDR_W-1:0] req_base;
   logic [XLEN-1:0]  ext_lo;
   logic [XLEN-1:0]  ext_hi;
   logic [XLEN-1:0]  ext_data;

   assign dec       = decode_size(req_funct3);
   assign req_off   = req_addr[OFF_W-1:0];
   assign req_cross = (5'(req_off) + 5'(dec.size)) > 5'(BYTES);
   assign req_bad   = is_illegal(req_funct3, XLEN == 64);
   assign req_base  = req_addr & ~ADDR_W'(BYTES - 1);
   assign state_dbg = state;

   // Result is built straight from the returning beat so it can be registered
   // on the same edge that sees mem_rvalid.
   assign ext_lo = (state == S_WAIT1) ? lo_q : mem_rdata;
   assign ext_hi = (state == S_WAIT1) ? mem_rdata : '0;

   load_extract #(.XLEN(XLEN)) u_extract (
      .lo   (ext_lo),
      .hi   (ext_hi),
      .off  (off_q),
      .size (size_q),
      .sgn  (sgn_q),
      .data (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         req_ready  <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         resp_cause <= CAUSE_NONE;
         off_q      <= '0;
         size_q     <= '0;
         sgn_q      <= 1'b0;
         cross_q    <= 1'b0;
         lo_q       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  off_q     <= req_off;
                  size_q    <= dec.size;
                  sgn_q     <= dec.sgn;
                  cross_q   <= req_cross;
                  if (req_bad) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_data  <= '0;
                     resp_err   <= 1'b1;
                     resp_cause <= CAUSE_ILLEGAL;
                  end else if (req_cross && MISALIGN_EN == 0) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_data  <= '0;
                     resp_err   <= 1'b1;
                     resp_cause <= CAUSE_MISALIGN;
                  end else begin
                     state    <= S_REQ0;
                     mem_req  <= 1'b1;
                     mem_addr <= req_base;
                  end
               end
            end
            S_REQ0: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= S_WAIT0;
               end
            end
            S_WAIT0: begin
               if (mem_rvalid) begin
                  lo_q <= mem_rdata;
                  if (mem_err) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_data  <= '0;
                     resp_err   <= 1'b1;
                     resp_cause <= CAUSE_BUS;
                  end else if (cross_q) begin
                     state    <= S_REQ1;
                     mem_req  <= 1'b1;
                     mem_addr <= mem_addr + ADDR_W'(BYTES);
                  end else begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_data  <= ext_data;
                     resp_err   <= 1'b0;
                     resp_cause <= CAUSE_NONE;
                  end
               end
            end
            S_REQ1: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= S_WAIT1;
               end
            end
            S_WAIT1: begin
               if (mem_rvalid) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_data  <= mem_err ? '0 : ext_data;
                  resp_err   <= mem_err;
                  resp_cause <= mem_err ? CAUSE_BUS : CAUSE_NONE;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: a 32-bit splitting instance and a 64-bit faulting
// instance share one bus responder and are compared against a byte-level model.
module tb_load_unit;
   import load_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic [2:0]  req_funct3 = '0;
   logic        resp_ready = 1'b0;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
   logic [63:0] mem_rdata = '0;

   logic        r32, q32, v32, e32;
   logic [31:0] a32, d32;
   logic [1:0]  c32;
   logic [2:0]  s32;
   logic        r64, q64, v64, e64;
   logic [31:0] a64;
   logic [63:0] d64;
   logic [1:0]  c64;
   logic [2:0]  s64;

   logic        o_ready, o_req, o_valid, o_err;
   logic [31:0] o_addr;
   logic [63:0] o_data;
   logic [1:0]  o_cause;
   logic [2:0]  o_state;

   int n_pass = 0, n_total = 0;

   logic [63:0] mem [logic [31:0]];
   logic [31:0] salt = 32'h1234_5678;
   int          gnt_stall = 0, rv_stall = 0;
   bit          err_on = 1'b0;
   logic [31:0] err_addr = '0;
   logic [31:0] issued_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   load_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1)) u32 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(r32),
      .req_addr(req_addr), .req_funct3(req_funct3), .mem_req(q32), .mem_addr(a32),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
      .mem_err(mem_err), .resp_valid(v32), .resp_ready(resp_ready && !sel),
      .resp_data(d32), .resp_err(e32), .resp_cause(c32), .state_dbg(s32));

   load_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(0)) u64 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(r64),
      .req_addr(req_addr), .req_funct3(req_funct3), .mem_req(q64), .mem_addr(a64),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_err(mem_err), .resp_valid(v64), .resp_ready(resp_ready && sel),
      .resp_data(d64), .resp_err(e64), .resp_cause(c64), .state_dbg(s64));

   assign o_ready = sel ? r64 : r32;
   assign o_req   = sel ? q64 : q32;
   assign o_addr  = sel ? a64 : a32;
   assign o_valid = sel ? v64 : v32;
   assign o_data  = sel ? d64 : {32'h0, d32};
   assign o_err   = sel ? e64 : e32;
   assign o_cause = sel ? c64 : c32;
   assign o_state = sel ? s64 : s32;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a ^ salt, (a * 32'h9E37_79B1) ^ ~salt};
   endfunction

   // Byte-by-byte reference: gather the accessed bytes from the words they
   // live in, then extend.
   function automatic void ref_load(input int xl, input bit mis, input logic [31:0] a,
                                    input logic [2:0] f3, output logic [63:0] d,
                                    output logic [1:0] c, output int nacc,
                                    output logic [31:0] a0, output logic [31:0] a1);
      int nb, sz, off, p;
      logic [63:0] bv;
      nb = xl / 8;
      sz = 1 << f3[1:0];
      off = int'(a % nb);
      a0 = a - off;
      a1 = a0 + nb;
      d = '0; c = 2'd0; nacc = 0;
      if (f3 == 3'b111 || (xl == 32 && (f3 == 3'b011 || f3 == 3'b110))) c = 2'd3;
      else if (off + sz > nb && !mis) c = 2'd1;
      else begin
         nacc = (off + sz > nb) ? 2 : 1;
         if (err_on && err_addr == a0) begin c = 2'd2; nacc = 1; end
         else if (nacc == 2 && err_on && err_addr == a1) c = 2'd2;
         else begin
            for (int i = 0; i < sz; i++) begin
               p = off + i;
               bv = (p < nb) ? mem_word(a0) : mem_word(a1);
               bv = (bv >> (8 * (p % nb))) & 64'hFF;
               d = d | (bv << (8 * i));
            end
            if (!f3[2] && sz * 8 < xl && d[sz*8-1]) d = d | (~64'h0 << (sz * 8));
            if (xl == 32) d[63:32] = '0;
         end
      end
   endfunction

   // Bus responder: grants after gnt_stall waiting cycles, returns data
   // rv_stall cycles after the grant; checks mem_addr is held while waiting.
   bit          pending = 1'b0, req_seen = 1'b0;
   int          req_age = 0, rv_age = 0;
   logic [31:0] paddr = '0, held_addr = '0;

   always @(negedge clk) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
      if (pending) begin
         if (rv_age >= rv_stall) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(paddr);
            mem_err    = err_on && (paddr == err_addr);
            pending    = 1'b0;
         end else rv_age++;
      end else if (o_req) begin
         if (req_seen) chk("mem_addr_stable", o_addr, held_addr);
         held_addr = o_addr;
         req_seen  = 1'b1;
         if (req_age >= gnt_stall) begin
            mem_gnt = 1'b1;
            issued_q.push_back(o_addr);
            paddr = o_addr; pending = 1'b1; rv_age = 0; req_age = 0; req_seen = 1'b0;
         end else req_age++;
      end else begin
         req_seen = 1'b0; req_age = 0;
      end
   end

   task automatic do_load(input bit s, input logic [31:0] a, input logic [2:0] f3,
                          input int gs, input int rs, input int ps,
                          output logic [63:0] got_d, output logic [1:0] got_c);
      logic [63:0] ed;
      logic [1:0]  ec;
      int          nacc, lat, exp_lat;
      logic [31:0] a0, a1;
      bit          done;
      ref_load(s ? 64 : 32, !s, a, f3, ed, ec, nacc, a0, a1);
      exp_lat = 1 + nacc * (2 + gs + rs);
      gnt_stall = gs; rv_stall = rs;
      issued_q.delete(); exp_q.delete();
      if (nacc >= 1) exp_q.push_back(a0);
      if (nacc == 2) exp_q.push_back(a1);
      sel = s;
      @(negedge clk);
      chk("req_ready_idle", o_ready, 1);
      req_addr = a; req_funct3 = f3; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      lat = 0; done = 1'b0;
      while (!done && lat < 100) begin
         @(negedge clk); lat++;
         if (o_valid) done = 1'b1;
      end
      chk("resp_seen", done, 1);
      chk("latency", lat, exp_lat);
      chk("resp_data", o_data, ed);
      chk("resp_err", o_err, ec != 2'd0);
      chk("resp_cause", o_cause, ec);
      got_d = o_data; got_c = o_cause;
      for (int i = 0; i < ps; i++) begin
         @(negedge clk);
         chk("hold_valid", o_valid, 1);
         chk("hold_data", o_data, got_d);
         chk("hold_cause", o_cause, got_c);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1 resp_ready = 1'b0;
      @(negedge clk);
      chk("resp_dropped", o_valid, 0);
      chk("req_count", issued_q.size(), exp_q.size());
      while (exp_q.size() > 0 && issued_q.size() > 0)
         chk("req_addr", issued_q.pop_front(), exp_q.pop_front());
   endtask

   logic [63:0] d;
   logic [1:0]  c;

   initial begin
      // reset state
      #3 rst_n = 1'b0;
      #1;
      chk("rst_req32", q32, 0);  chk("rst_req64", q64, 0);
      chk("rst_addr32", a32, 0); chk("rst_addr64", a64, 0);
      chk("rst_valid32", v32, 0); chk("rst_valid64", v64, 0);
      chk("rst_data32", d32, 0); chk("rst_data64", d64, 0);
      chk("rst_err", {e32, e64}, 0); chk("rst_cause", {c32, c64}, 0);
      chk("rst_ready32", r32, 0); chk("rst_ready64", r64, 0);
      chk("rst_state", s32, 64'(S_IDLE));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst32", r32, 1); chk("ready_after_rst64", r64, 1);

      mem[32'h100] = 64'hDEADBEEF;
      do_load(0, 32'h100, F3_LW, 0, 0, 0, d, c);
      chk("lw_const", d, 64'hDEADBEEF);

      mem[32'h100] = 64'h80FF0000;
      do_load(0, 32'h103, F3_LB, 0, 0, 0, d, c);
      chk("lb_const", d, 64'hFFFFFF80);
      do_load(0, 32'h103, F3_LBU, 0, 0, 0, d, c);
      chk("lbu_const", d, 64'h00000080);

      mem[32'h100] = 64'h8000000100000000;
      do_load(1, 32'h104, F3_LWU, 0, 0, 0, d, c);
      chk("lwu64_const", d, 64'h0000000080000001);

      mem[32'h100] = 64'hAABBCCDD;
      mem[32'h104] = 64'h11223344;
      do_load(0, 32'h102, F3_LW, 0, 0, 0, d, c);
      chk("split_const", d, 64'h3344AABB);

      do_load(1, 32'h0FF, F3_LH, 0, 0, 0, d, c);
      chk("misalign_cause", c, 2'd1);
      do_load(0, 32'h100, F3_BAD, 0, 0, 0, d, c);
      chk("illegal_cause", c, 2'd3);
      do_load(0, 32'h100, F3_LD, 0, 0, 0, d, c);
      chk("ld32_illegal", c, 2'd3);

      err_on = 1'b1; err_addr = 32'h100;
      do_load(0, 32'h102, F3_LW, 0, 0, 0, d, c);
      chk("buserr_cause", c, 2'd2);
      err_addr = 32'h104;
      do_load(0, 32'h102, F3_LW, 0, 1, 0, d, c);
      err_on = 1'b0;

      do_load(0, 32'h202, F3_LH, 4, 0, 5, d, c);
      do_load(0, 32'h101, F3_LHU, 0, 2, 0, d, c);
      do_load(0, 32'hFFFF_FFFE, F3_LW, 1, 1, 1, d, c);
      do_load(1, 32'h108, F3_LD, 0, 0, 2, d, c);

      // reset pulsed while the first read is outstanding
      sel = 1'b0; gnt_stall = 0; rv_stall = 4; issued_q.delete();
      @(negedge clk);
      req_addr = 32'h200; req_funct3 = F3_LW; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("in_wait0", s32, 64'(S_WAIT0));
      rst_n = 1'b0;
      #1;
      chk("midrst_req", q32, 0);
      chk("midrst_ready", r32, 0);
      chk("midrst_state", s32, 64'(S_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("late_rvalid_sent", pending, 0);
      chk("late_rvalid_ignored", v32, 0);
      chk("late_state", s32, 64'(S_IDLE));
      chk("late_ready", r32, 1);
      do_load(0, 32'h104, F3_LW, 0, 0, 0, d, c);

      for (int n = 0; n < 60; n++) begin
         logic [31:0] a, base;
         bit          s;
         s = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 32'h3FF);
         salt = $urandom;
         mem.delete();
         base = s ? (a & ~32'h7) : (a & ~32'h3);
         err_on = ($urandom_range(0, 5) == 0);
         err_addr = $urandom_range(0, 1) ? base : base + (s ? 32'd8 : 32'd4);
         do_load(s, a, 3'($urandom_range(0, 7)), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2), d, c);
      end
      err_on = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/load_unit.md
# load_unit

Multi-cycle, parametrised load path between the core's execute stage and the data-memory bus. Accepts one load at a time over a valid/ready handshake, issues one or two word-aligned bus reads, and returns a sign- or zero-extended result. It replaces the combinational byte/half extractor, adding XLEN=64 support, split handling of word-crossing loads, bus back-pressure and error reporting.

## Interface
- XLEN, 32, data width in bits; legal values are 32 and 64. BYTES = XLEN/8.
- ADDR_W, 32, address width.
- MISALIGN_EN, 1, 1 = split word-crossing loads into two accesses; 0 = raise a misaligned error instead.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in / out  1  load request handshake.
- req_addr  in  ADDR_W  byte address.
- req_funct3  in  3  RISC-V load funct3: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110.
- mem_req  out  1  bus read request.
- mem_addr  out  ADDR_W  word-aligned address (low log2(BYTES) bits are 0).
- mem_gnt  in  1  bus accepts the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data, little-endian.
- mem_err  in  1  bus error; qualified by mem_rvalid.
- resp_valid / resp_ready  out / in  1  result handshake.
- resp_data  out  XLEN  extended load result.
- resp_err  out  1  load faulted.
- resp_cause  out  2  0 none, 1 misaligned, 2 bus error, 3 illegal funct3.

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- req_ready = (state==IDLE). On acceptance, addr, funct3 and size are latched, and off = addr[log2(BYTES)-1:0].
- Illegal funct3 is 111, or 011/110 when XLEN=32. It goes IDLE→RESP with cause 3 and no bus access.
- cross = off+size > BYTES. If cross and MISALIGN_EN=0: IDLE→RESP with cause 1 and no bus access. A non-crossing unaligned load (e.g. LH at off 1) is legal and uses a single access.
- Otherwise IDLE→REQ0.
- REQ0: mem_req=1, mem_addr = addr with low bits cleared. mem_addr is held stable until mem_gnt, then the state goes to WAIT0.
- WAIT0: on mem_rvalid, capture lo=mem_rdata.
  - mem_err → RESP with cause 2.
  - else cross → REQ1.
  - else → RESP.
- REQ1/WAIT1: same as REQ0/WAIT0, but at aligned addr+BYTES (wraps modulo 2^ADDR_W) and capturing hi. mem_err → cause 2.
- Result: ({hi,lo} >> 8*off), truncated to the size in bytes, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to XLEN. LD is full width. hi is treated as 0 when not fetched.
- Any error forces resp_data=0 and resp_err=1.
- RESP: resp_valid=1. resp_data/err/cause are registered and held stable until resp_ready, then the state goes to IDLE.
- mem_rvalid outside WAIT0/WAIT1 is ignored. The bus guarantees at most one outstanding read.

## Timing
- Reset (async assert): state=IDLE. mem_req, mem_addr, resp_valid, resp_data, resp_err and resp_cause are all 0 immediately. req_ready=0 while rst_n=0, and 1 from the first cycle after release.
- Aligned load, with mem_gnt in the same cycle as mem_req and mem_rvalid on the next cycle:
  - accept at edge 0.
  - mem_req in cycle 1.
  - rvalid in cycle 2.
  - resp_valid in cycle 3, i.e. 3 cycles from acceptance.
- A split load adds 2 cycles. Each stall cycle on mem_gnt or mem_rvalid adds 1 cycle.
- Error short-circuits (cause 1 or 3): resp_valid in the cycle after acceptance.
- Back-to-back throughput: one load per (latency+1) cycles. IDLE is mandatory between loads.
- Reset mid-operation: mem_req drops asynchronously, and a bus response arriving after reset release is ignored.

## Structure
- Package `load_pkg` holds:
  - funct3 localparams.
  - state encodings.
  - cause codes.
  - a size-decode function (funct3 → bytes, and signed flag).
- Sub-module `load_extract`: purely combinational shift/truncate/extend. Inputs are lo, hi, off, size and signed; parametrised on XLEN. The FSM and registers live in `load_unit`.

## Test plan
- XLEN=32, LW at 0x100, rdata 0xDEADBEEF, immediate gnt → exactly one mem_req (addr 0x100), resp_data 0xDEADBEEF, resp_valid 3 cycles after accept.
- LB at 0x103, rdata 0x80FF0000 → 0xFFFFFF80. LBU at the same address → 0x00000080. XLEN=64 LWU at 0x104, rdata 0x8000000100000000 → 0x0000000080000001.
- MISALIGN_EN=1, LW at 0x102, reads 0x100→0xAABBCCDD and 0x104→0x11223344 → two requests in order, resp_data 0x3344AABB, resp_valid 5 cycles after accept.
- MISALIGN_EN=0, LH at 0x0FF → no mem_req, resp_err=1, cause 1. Funct3 111 → cause 3, no mem_req.
- Split load with mem_err on the first rvalid → no second mem_req, resp_data 0, cause 2.
- mem_gnt held low 4 cycles → mem_addr stable throughout. resp_ready low 5 cycles → resp_data stable. rst_n pulsed in WAIT0 → mem_req 0 at once, a later rvalid is ignored, req_ready=1 after release.
